// File: rtl/memwrite_checker.sv
// Watches the data-memory write bus and checks it against an ordered list of expected
// address/data pairs, reporting pass, fail with a cause code, or timeout.
module memwrite_checker #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned NUM_CHECKS     = 4,
    parameter bit          STRICT         = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        memwrite,
    input  logic [WIDTH-1:0]            dataadr,
    input  logic [WIDTH-1:0]            writedata,
    input  logic [NUM_CHECKS*WIDTH-1:0] exp_addr,
    input  logic [NUM_CHECKS*WIDTH-1:0] exp_data,
    output logic                        busy,
    output logic                        pass,
    output logic                        fail,
    output logic [1:0]                  fail_code,
    output logic [3:0]                  check_idx,
    output logic [CNT_W-1:0]            write_count,
    output logic [CNT_W-1:0]            cycle_count
);

    typedef enum logic [1:0] {StIdle, StRun, StPass, StFail} state_e;

    localparam logic [1:0] FcNone    = 2'b00;
    localparam logic [1:0] FcData    = 2'b01;
    localparam logic [1:0] FcAddr    = 2'b10;
    localparam logic [1:0] FcTimeout = 2'b11;

    localparam logic [3:0]       LastIdx     = 4'(NUM_CHECKS - 1);
    localparam logic [CNT_W-1:0] CntMax      = '1;
    localparam logic [CNT_W-1:0] TimeoutLast =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : (TIMEOUT_CYCLES - 1));

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic [1:0]       fail_code_q, fail_code_d;
    logic [3:0]       check_idx_q, check_idx_d;
    logic [CNT_W-1:0] write_count_q, write_count_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

    logic [WIDTH-1:0] cur_addr;
    logic [WIDTH-1:0] cur_data;
    logic             addr_hit;
    logic             data_hit;
    logic             last_entry;
    logic             timeout_hit;
    logic             wr_match;
    logic             wr_data_bad;
    logic             wr_addr_bad;

    // Only the entry at check_idx is ever compared, so later entries cannot match early.
    always_comb begin
        cur_addr = '0;
        cur_data = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (check_idx_q == 4'(i)) begin
                cur_addr = exp_addr[i*WIDTH +: WIDTH];
                cur_data = exp_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign addr_hit    = (dataadr == cur_addr);
    assign data_hit    = (writedata == cur_data);
    assign last_entry  = (check_idx_q == LastIdx);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_count_q == TimeoutLast);
    assign wr_match    = memwrite && addr_hit && data_hit;
    assign wr_data_bad = memwrite && addr_hit && !data_hit;
    assign wr_addr_bad = memwrite && !addr_hit && STRICT;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            busy_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            fail_code_q   <= FcNone;
            check_idx_q   <= '0;
            write_count_q <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            fail_code_q   <= fail_code_d;
            check_idx_q   <= check_idx_d;
            write_count_q <= write_count_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    // A write decision takes precedence over a timeout landing on the same edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StRun;
            end
            StRun: begin
                if (start) begin
                    state_d = StRun;
                end else if (wr_match && last_entry) begin
                    state_d = StPass;
                end else if (wr_data_bad || wr_addr_bad) begin
                    state_d = StFail;
                end else if (timeout_hit) begin
                    state_d = StFail;
                end
            end
            StPass, StFail: begin
                if (start) state_d = StRun;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fail_code_d   = fail_code_q;
        check_idx_d   = check_idx_q;
        write_count_d = write_count_q;
        cycle_count_d = cycle_count_q;
        if (start) begin
            fail_code_d   = FcNone;
            check_idx_d   = '0;
            write_count_d = '0;
            cycle_count_d = '0;
        end else if (state_q == StRun) begin
            cycle_count_d = cycle_count_q + 1'b1;
            if (memwrite && (write_count_q != CntMax)) begin
                write_count_d = write_count_q + 1'b1;
            end
            if (wr_match && !last_entry) begin
                check_idx_d = check_idx_q + 4'd1;
            end
            if (state_d == StFail) begin
                if (wr_data_bad) begin
                    fail_code_d = FcData;
                end else if (wr_addr_bad) begin
                    fail_code_d = FcAddr;
                end else begin
                    fail_code_d = FcTimeout;
                end
            end
        end
    end

    always_comb begin
        busy_d = (state_d == StRun);
        pass_d = (state_d == StPass);
        fail_d = (state_d == StFail);
    end

    assign busy        = busy_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign fail_code   = fail_code_q;
    assign check_idx   = check_idx_q;
    assign write_count = write_count_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_memwrite_checker.sv
// Two checker instances (lenient/no-timeout/narrow counters, strict/short-timeout) share one
// write bus; a transaction-level model predicts every output each cycle.
module tb_memwrite_checker;

    localparam int W     = 8;
    localparam int NL    = 3;
    localparam int NS    = 2;
    localparam int CWL   = 6;
    localparam int CWS   = 32;
    localparam int TMO_S = 20;

    localparam int MIdle = 0;
    localparam int MRun  = 1;
    localparam int MPass = 2;
    localparam int MFail = 3;

    typedef struct {
        int     ph;
        int     idx;
        longint wc;
        longint cc;
        int     fc;
    } mst_t;

    logic           clk;
    logic           reset;
    logic           start;
    logic           memwrite;
    logic [W-1:0]   dataadr;
    logic [W-1:0]   writedata;
    logic [W-1:0]   la[4], ld[4], sa[4], sd[4];
    logic [NL*W-1:0] exp_addr_l, exp_data_l;
    logic [NS*W-1:0] exp_addr_s, exp_data_s;

    logic           busy_l, pass_l, fail_l, busy_s, pass_s, fail_s;
    logic [1:0]     fc_l, fc_s;
    logic [3:0]     idx_l, idx_s;
    logic [CWL-1:0] wc_l, cc_l;
    logic [CWS-1:0] wc_s, cc_s;

    int   checks = 0;
    int   errors = 0;
    mst_t ml, ms;

    assign exp_addr_l = {la[2], la[1], la[0]};
    assign exp_data_l = {ld[2], ld[1], ld[0]};
    assign exp_addr_s = {sa[1], sa[0]};
    assign exp_data_s = {sd[1], sd[0]};

    memwrite_checker #(
        .WIDTH(W), .NUM_CHECKS(NL), .STRICT(1'b0), .TIMEOUT_CYCLES(0), .CNT_W(CWL)
    ) u_dut_l (
        .clk(clk), .reset(reset), .start(start), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .exp_addr(exp_addr_l), .exp_data(exp_data_l), .busy(busy_l),
        .pass(pass_l), .fail(fail_l), .fail_code(fc_l), .check_idx(idx_l),
        .write_count(wc_l), .cycle_count(cc_l)
    );

    memwrite_checker #(
        .WIDTH(W), .NUM_CHECKS(NS), .STRICT(1'b1), .TIMEOUT_CYCLES(TMO_S), .CNT_W(CWS)
    ) u_dut_s (
        .clk(clk), .reset(reset), .start(start), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .exp_addr(exp_addr_s), .exp_data(exp_data_s), .busy(busy_s),
        .pass(pass_s), .fail(fail_s), .fail_code(fc_s), .check_idx(idx_s),
        .write_count(wc_s), .cycle_count(cc_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic mst_t mzero();
        mst_t r;
        r.ph = MIdle; r.idx = 0; r.wc = 0; r.cc = 0; r.fc = 0;
        return r;
    endfunction

    // One clock edge of the checker, described as the rules state it.
    function automatic mst_t model_step(input mst_t m, input logic st_in, input logic mw,
                                        input logic [7:0] a, input logic [7:0] d,
                                        input logic [7:0] ea[4], input logic [7:0] ed[4],
                                        input int n, input bit strict, input int tmo,
                                        input int cw);
        mst_t   r;
        longint maxv;
        bit     decided;
        r = m;
        maxv = (longint'(1) << cw) - 1;
        decided = 1'b0;
        if (st_in) begin
            r = mzero();
            r.ph = MRun;
            return r;
        end
        if (m.ph != MRun) return r;
        r.cc = (m.cc + 1) & maxv;
        if (mw) begin
            r.wc = (m.wc == maxv) ? maxv : m.wc + 1;
            if (a == ea[m.idx]) begin
                if (d != ed[m.idx]) begin
                    r.ph = MFail; r.fc = 1; decided = 1'b1;
                end else if (m.idx == n - 1) begin
                    r.ph = MPass; decided = 1'b1;
                end else begin
                    r.idx = m.idx + 1;
                end
            end else if (strict) begin
                r.ph = MFail; r.fc = 2; decided = 1'b1;
            end
        end
        if (!decided && tmo != 0 && m.cc == longint'(tmo - 1)) begin
            r.ph = MFail; r.fc = 3;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic cmp_all();
        chk("l.busy", busy_l, ml.ph == MRun);
        chk("l.pass", pass_l, ml.ph == MPass);
        chk("l.fail", fail_l, ml.ph == MFail);
        chk("l.fail_code", fc_l, ml.fc);
        chk("l.check_idx", idx_l, ml.idx);
        chk("l.write_count", wc_l, ml.wc);
        chk("l.cycle_count", cc_l, ml.cc);
        chk("s.busy", busy_s, ms.ph == MRun);
        chk("s.pass", pass_s, ms.ph == MPass);
        chk("s.fail", fail_s, ms.ph == MFail);
        chk("s.fail_code", fc_s, ms.fc);
        chk("s.check_idx", idx_s, ms.idx);
        chk("s.write_count", wc_s, ms.wc);
        chk("s.cycle_count", cc_s, ms.cc);
    endtask

    always @(negedge reset) begin
        ml = mzero();
        ms = mzero();
    end

    always @(posedge clk) begin
        if (!reset) begin
            ml = mzero();
            ms = mzero();
        end else begin
            ml = model_step(ml, start, memwrite, dataadr, writedata, la, ld, NL, 1'b0, 0, CWL);
            ms = model_step(ms, start, memwrite, dataadr, writedata, sa, sd, NS, 1'b1, TMO_S,
                            CWS);
        end
        #1;
        cmp_all();
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        tick(1);
        memwrite  = 1'b0;
    endtask

    initial begin
        int         r;
        logic [7:0] a, d;
        ml = mzero();
        ms = mzero();
        reset = 1'b0; start = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
        la = '{8'd92, 8'd84, 8'd100, 8'd0};
        ld = '{8'd5, 8'd7, 8'd9, 8'd0};
        sa = '{8'd84, 8'd92, 8'd0, 8'd0};
        sd = '{8'd7, 8'd5, 8'd0, 8'd0};
        tick(1);
        chk("rst.busy", busy_l, 0);
        chk("rst.pass", pass_l, 0);
        chk("rst.fail", fail_l, 0);
        chk("rst.cycle_count", cc_s, 0);
        reset = 1'b1;

        // Lenient pass with an ignored write; strict instance fails on the same write.
        pulse_start();
        chk("start.busy", busy_l, 1);
        wr(8'd80, 8'd7);
        chk("strict.fail", fail_s, 1);
        chk("strict.code", fc_s, 2);
        chk("strict.wc", wc_s, 1);
        wr(8'd92, 8'd5);
        wr(8'd84, 8'd7);
        wr(8'd100, 8'd9);
        chk("pass.pass", pass_l, 1);
        chk("pass.code", fc_l, 0);
        chk("pass.wc", wc_l, 4);
        chk("pass.idx", idx_l, 2);
        chk("pass.cc", cc_l, 4);
        tick(3);
        chk("pass.sticky", pass_l, 1);
        chk("pass.frozen_cc", cc_l, 4);

        // Restart from PASS, then a data mismatch on the second strict entry.
        pulse_start();
        chk("restart.busy", busy_l, 1);
        chk("restart.pass", pass_l, 0);
        chk("restart.cc", cc_l, 0);
        chk("restart.fail_s", fail_s, 0);
        wr(8'd84, 8'd7);
        wr(8'd92, 8'd6);
        chk("mism.fail", fail_s, 1);
        chk("mism.code", fc_s, 1);
        chk("mism.idx", idx_s, 1);
        chk("mism.pass", pass_s, 0);

        // Timeout after 20 idle RUN cycles.
        pulse_start();
        tick(19);
        chk("tmo.before", busy_s, 1);
        chk("tmo.cc19", cc_s, 19);
        tick(1);
        chk("tmo.fail", fail_s, 1);
        chk("tmo.code", fc_s, 3);
        chk("tmo.cc", cc_s, 20);

        // Final matching write on the timeout cycle wins.
        pulse_start();
        wr(8'd84, 8'd7);
        tick(18);
        chk("race.cc19", cc_s, 19);
        wr(8'd92, 8'd5);
        chk("race.pass", pass_s, 1);
        chk("race.fail", fail_s, 0);
        chk("race.cc", cc_s, 20);

        // Asynchronous reset mid-RUN.
        chk("arst.pre_busy", busy_l, 1);
        #1 reset = 1'b0;
        #1;
        chk("arst.busy", busy_l, 0);
        chk("arst.idx", idx_l, 0);
        chk("arst.pass_s", pass_s, 0);
        #1 reset = 1'b1;
        tick(1);
        tick(3);
        chk("arst.idle", busy_l, 0);

        // Saturating write counter and wrapping cycle counter on the 6-bit instance.
        pulse_start();
        memwrite = 1'b1; dataadr = 8'hff; writedata = 8'h00;
        tick(70);
        memwrite = 1'b0;
        chk("sat.wc", wc_l, 63);
        chk("sat.cc", cc_l, 6);
        chk("sat.busy", busy_l, 1);

        for (int c = 0; c < 3000; c++) begin
            if (!busy_l && !busy_s) start = ($urandom_range(0, 2) == 0);
            else start = ($urandom_range(0, 149) == 0);
            if (start) begin
                for (int i = 0; i < 4; i++) begin
                    la[i] = 8'($urandom); ld[i] = 8'($urandom);
                    sa[i] = 8'($urandom); sd[i] = 8'($urandom);
                end
            end
            memwrite = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 7);
            if (r < 4) begin
                a = la[ml.idx]; d = ld[ml.idx];
            end else if (r < 6) begin
                a = sa[ms.idx]; d = sd[ms.idx];
            end else begin
                a = 8'($urandom); d = 8'($urandom);
            end
            if ($urandom_range(0, 9) == 0) d = d ^ 8'(1 << $urandom_range(0, 7));
            dataadr = a;
            writedata = d;
            if ($urandom_range(0, 499) == 0) begin
                #1 reset = 1'b0;
                #3 reset = 1'b1;
            end
            @(negedge clk);
        end

        start = 1'b0;
        memwrite = 1'b0;
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
